// File: rtl/acumulador_multimodo_if.sv
// Control/status bundle of the SAP-1 multimode accumulator (the tristate bus
// output stays a plain port on the module so it can resolve onto the shared bus).
interface acumulador_multimodo_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
);
    logic             La;
    logic             Ea;
    logic             start;
    logic [2:0]       op;
    logic [CNT_W-1:0] shamt;
    logic [WIDTH-1:0] entrada;
    logic [WIDTH-1:0] para_ula;
    logic             busy;
    logic             done;
    logic             zero;
    logic             neg;
    logic             carry;

    modport master (
        output La, Ea, start, op, shamt, entrada,
        input  para_ula, busy, done, zero, neg, carry
    );

    modport slave (
        input  La, Ea, start, op, shamt, entrada,
        output para_ula, busy, done, zero, neg, carry
    );
endinterface

// File: rtl/acumulador_multimodo.sv
// SAP-1 accumulator: load, clear/inc/dec in one cycle, shift/rotate one bit per cycle.
// Status flags and the carry register exist only when ACUMULADOR_FLAGS_EN is defined.
module acumulador_multimodo #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic                  CLK,
    input  logic                  CLR,
    acumulador_multimodo_if.slave bus,
    output logic [WIDTH-1:0]      para_barramento
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [2:0] OP_CLEAR = 3'b001;
    localparam logic [2:0] OP_INC   = 3'b010;
    localparam logic [2:0] OP_DEC   = 3'b011;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             acc_we;
    logic [CNT_W-1:0] count;
    logic [1:0]       kind;
    logic             busy_q;
    logic             done_q;

    // kind: 00 SHL, 01 SHR, 10 ROL, 11 ROR (low bits of the shift opcodes)
    function automatic logic [WIDTH-1:0] shift1(input logic [1:0] k, input logic [WIDTH-1:0] v);
        case (k)
            2'b00:   shift1 = {v[WIDTH-2:0], 1'b0};
            2'b01:   shift1 = {1'b0, v[WIDTH-1:1]};
            2'b10:   shift1 = {v[WIDTH-2:0], v[WIDTH-1]};
            default: shift1 = {v[0], v[WIDTH-1:1]};
        endcase
    endfunction

    always_comb begin
        acc_nxt = acc;
        acc_we  = 1'b0;
        case (state)
            IDLE: begin
                if (bus.La) begin
                    acc_nxt = bus.entrada;
                    acc_we  = 1'b1;
                end else if (bus.start) begin
                    case (bus.op)
                        OP_CLEAR: begin acc_nxt = '0;          acc_we = 1'b1; end
                        OP_INC:   begin acc_nxt = acc + 1'b1;  acc_we = 1'b1; end
                        OP_DEC:   begin acc_nxt = acc - 1'b1;  acc_we = 1'b1; end
                        default:  ;
                    endcase
                end
            end
            SHIFT: begin
                acc_nxt = shift1(kind, acc);
                acc_we  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state  <= IDLE;
            acc    <= '0;
            count  <= '0;
            kind   <= 2'b00;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            if (acc_we) acc <= acc_nxt;
            case (state)
                IDLE: begin
                    // La wins over start in the same cycle
                    if (!bus.La && bus.start) begin
                        busy_q <= 1'b1;
                        if (bus.op[2] && bus.shamt != '0) begin
                            kind  <= bus.op[1:0];
                            count <= bus.shamt;
                            state <= SHIFT;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    count <= count - 1'b1;
                    if (count == CNT_W'(1)) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ACUMULADOR_FLAGS_EN
    logic carry_q;
    logic carry_nxt;

    // Only consumed when acc_we is set, so don't-care paths may produce anything.
    always_comb begin
        carry_nxt = 1'b0;
        if (state == SHIFT) begin
            carry_nxt = kind[0] ? acc[0] : acc[WIDTH-1];
        end else if (!bus.La) begin
            case (bus.op)
                OP_INC:  carry_nxt = &acc;
                OP_DEC:  carry_nxt = ~|acc;
                default: carry_nxt = 1'b0;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) carry_q <= 1'b0;
        else if (acc_we) carry_q <= carry_nxt;
    end

    assign bus.zero  = (acc == '0);
    assign bus.neg   = acc[WIDTH-1];
    assign bus.carry = carry_q;
`else
    assign bus.zero  = 1'b0;
    assign bus.neg   = 1'b0;
    assign bus.carry = 1'b0;
`endif

    assign bus.para_ula    = acc;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign para_barramento = bus.Ea ? acc : {WIDTH{1'bz}};
endmodule
